// File: rtl/fps_gate_ctrl.sv
// Frame-rate gate sequencer: synchronises vsync, arms on the first edge, counts
// vsync rising edges over back-to-back fixed windows (binary and BCD), and
// hands each result out over valid/ready. Also tracks min/max and detects a
// stalled source.
module fps_gate_ctrl #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned GATE_CYCLES  = 50_000_000,
    parameter int unsigned STALL_CYCLES = 12_500_000
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       vs,
    input  logic       enable,
    input  logic       clr_minmax,
    input  logic       fps_ready,
    output logic       fps_valid,
    output logic [7:0] fps,
    output logic [7:0] fps_bcd,
    output logic [7:0] fps_min,
    output logic [7:0] fps_max,
    output logic       stalled,
    output logic       overflow
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam int unsigned SW = $clog2(STALL_CYCLES);
    localparam logic [GW-1:0] GATE_LAST  = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    // Reject parameter sets the counters cannot represent.
    if (GATE_CYCLES < 2 || STALL_CYCLES < 2 || CLK_HZ == 0) begin : g_param_check
        $error("fps_gate_ctrl: GATE_CYCLES and STALL_CYCLES must be >= 2, CLK_HZ nonzero");
    end

    logic          vs_s1, vs_s2, vs_d;
    logic          rise;
    logic [1:0]    state;
    logic [GW-1:0] gate_cnt;
    logic [SW-1:0] stall_cnt;
    logic [7:0]    bin_cnt, bin_next;
    logic [7:0]    bcd_cnt, bcd_inc, bcd_next;
    logic          gate_last, stall_hit, load;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk50) begin
        if (reset) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            vs_s1 <= vs;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
        end
    end

    assign rise      = vs_s2 & ~vs_d;
    assign gate_last = (gate_cnt == GATE_LAST);
    assign stall_hit = ~rise && (stall_cnt == STALL_LAST);
    // Stall takes precedence over a window end: an aborted window never loads.
    assign load      = enable && (state == RUN) && gate_last && !stall_hit;

    // Edge-count increment including a rise on the current cycle.
    always_comb begin
        bin_next = bin_cnt;
        bcd_inc  = bcd_cnt;
        if (bcd_cnt != 8'h99) begin
            if (bcd_cnt[3:0] == 4'd9)
                bcd_inc = {bcd_cnt[7:4] + 4'd1, 4'd0};
            else
                bcd_inc = {bcd_cnt[7:4], bcd_cnt[3:0] + 4'd1};
        end
        bcd_next = bcd_cnt;
        if (rise) begin
            if (bin_cnt != 8'hFF)
                bin_next = bin_cnt + 8'd1;
            bcd_next = bcd_inc;
        end
    end

    // Sequencer: arming, gate window timing, stall detection and edge counters.
    always_ff @(posedge clk50) begin
        if (reset || !enable) begin
            state     <= IDLE;
            gate_cnt  <= '0;
            stall_cnt <= '0;
            bin_cnt   <= '0;
            bcd_cnt   <= '0;
            stalled   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= ARM;
                    gate_cnt  <= '0;
                    stall_cnt <= '0;
                end
                ARM: begin
                    if (rise) begin
                        state     <= RUN;
                        gate_cnt  <= '0;
                        stall_cnt <= '0;
                        bin_cnt   <= '0;
                        bcd_cnt   <= '0;
                        stalled   <= 1'b0;
                    end else if (stall_hit) begin
                        stalled   <= 1'b1;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (stall_hit) begin
                        state     <= ARM;
                        stalled   <= 1'b1;
                        gate_cnt  <= '0;
                        stall_cnt <= '0;
                        bin_cnt   <= '0;
                        bcd_cnt   <= '0;
                    end else begin
                        stall_cnt <= rise ? '0 : stall_cnt + 1'b1;
                        if (rise)
                            stalled <= 1'b0;
                        if (gate_last) begin
                            gate_cnt <= '0;
                            bin_cnt  <= '0;
                            bcd_cnt  <= '0;
                        end else begin
                            gate_cnt <= gate_cnt + 1'b1;
                            bin_cnt  <= bin_next;
                            bcd_cnt  <= bcd_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result register and valid/ready handshake with sticky overwrite flag.
    always_ff @(posedge clk50) begin
        if (reset) begin
            fps_valid <= 1'b0;
            fps       <= '0;
            fps_bcd   <= '0;
            overflow  <= 1'b0;
        end else if (!enable) begin
            fps_valid <= 1'b0;
        end else if (load) begin
            fps       <= bin_next;
            fps_bcd   <= bcd_next;
            fps_valid <= 1'b1;
            if (fps_valid && !fps_ready)
                overflow <= 1'b1;
        end else if (fps_valid && fps_ready) begin
            fps_valid <= 1'b0;
        end
    end

    // Running min/max of completed windows; a clear coinciding with a load seeds both.
    always_ff @(posedge clk50) begin
        if (reset) begin
            fps_min <= '1;
            fps_max <= '0;
        end else if (load && clr_minmax) begin
            fps_min <= bin_next;
            fps_max <= bin_next;
        end else if (load) begin
            if (bin_next < fps_min)
                fps_min <= bin_next;
            if (bin_next > fps_max)
                fps_max <= bin_next;
        end else if (clr_minmax) begin
            fps_min <= '1;
            fps_max <= '0;
        end
    end

endmodule

// File: tb/tb_fps_gate_ctrl.sv
// Scoreboard bench for fps_gate_ctrl: stimulus pushes expected results, a
// monitor pops and compares on every accepted result.
module tb_fps_gate_ctrl;

    typedef struct packed {
        logic [7:0] fps;
        logic [7:0] bcd;
        logic [7:0] mn;
        logic [7:0] mx;
        logic       ovf;
    } exp_t;

    logic clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    logic       reset = 1'b1;
    logic       vs = 1'b0, enable = 1'b0, clr_minmax = 1'b0, fps_ready = 1'b1;
    logic       fps_valid, stalled, overflow;
    logic [7:0] fps, fps_bcd, fps_min, fps_max;

    logic       vs5 = 1'b0, enable5 = 1'b0;
    logic       fps_valid5, stalled5, overflow5;
    logic [7:0] fps5, fps_bcd5, fps_min5, fps_max5;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    fps_gate_ctrl #(.GATE_CYCLES(100), .STALL_CYCLES(40)) dut (
        .clk50(clk50), .reset(reset), .vs(vs), .enable(enable),
        .clr_minmax(clr_minmax), .fps_ready(fps_ready), .fps_valid(fps_valid),
        .fps(fps), .fps_bcd(fps_bcd), .fps_min(fps_min), .fps_max(fps_max),
        .stalled(stalled), .overflow(overflow)
    );

    fps_gate_ctrl #(.GATE_CYCLES(1000), .STALL_CYCLES(40)) dut5 (
        .clk50(clk50), .reset(reset), .vs(vs5), .enable(enable5),
        .clr_minmax(1'b0), .fps_ready(fps_ready), .fps_valid(fps_valid5),
        .fps(fps5), .fps_bcd(fps_bcd5), .fps_min(fps_min5), .fps_max(fps_max5),
        .stalled(stalled5), .overflow(overflow5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] f, input logic [7:0] b,
                                input logic [7:0] mn, input logic [7:0] mx, input logic o);
        exp_t e;
        e.fps = f; e.bcd = b; e.mn = mn; e.mx = mx; e.ovf = o;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    // n vsync periods of p cycles, each starting with a rising edge
    task automatic vs_run(input int n, input int p);
        for (int i = 0; i < n; i++) begin
            vs = 1'b1;
            tick(p / 2);
            vs = 1'b0;
            tick(p - p / 2);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; enable5 = 1'b0; clr_minmax = 1'b0;
        fps_ready = 1'b1; vs = 1'b0; vs5 = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    // Monitor for the GATE_CYCLES=100 instance
    initial forever begin
        @(negedge clk50);
        if (reset === 1'b0 && fps_valid === 1'b1 && fps_ready === 1'b1) begin
            if (q_a.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_result_a: got fps=%0d, expected no result at %0t", fps, $time);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_fps", fps, e.fps);
                chk("a_bcd", fps_bcd, e.bcd);
                chk("a_min", fps_min, e.mn);
                chk("a_max", fps_max, e.mx);
                chk("a_ovf", overflow, e.ovf);
            end
        end
    end

    // Monitor for the GATE_CYCLES=1000 instance
    initial forever begin
        @(negedge clk50);
        if (reset === 1'b0 && fps_valid5 === 1'b1 && fps_ready === 1'b1) begin
            if (q_b.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_result_b: got fps=%0d, expected no result at %0t", fps5, $time);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_fps", fps5, e.fps);
                chk("b_bcd", fps_bcd5, e.bcd);
                chk("b_min", fps_min5, e.mn);
                chk("b_max", fps_max5, e.mx);
                chk("b_ovf", overflow5, e.ovf);
            end
        end
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", fps_valid, 1'b0);
        chk("rst_fps", fps, 8'h00);
        chk("rst_bcd", fps_bcd, 8'h00);
        chk("rst_min", fps_min, 8'hFF);
        chk("rst_max", fps_max, 8'h00);
        chk("rst_stalled", stalled, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_min5", fps_min5, 8'hFF);

        // 1: period 10, ready=1, three windows of 10 edges
        for (int i = 0; i < 3; i++) q_a.push_back(mk(8'd10, 8'h10, 8'd10, 8'd10, 1'b0));
        enable = 1'b1;
        tick(2);
        fork
            vs_run(31, 10);
            begin
                tick(102); chk("t1_valid_pre", fps_valid, 1'b0);
                tick(1);   chk("t1_valid_load", fps_valid, 1'b1);
                tick(1);   chk("t1_valid_pulse", fps_valid, 1'b0);
            end
        join
        tick(10);

        // 2: consumer stalls across two loads -> sticky overflow
        do_reset();
        q_a.push_back(mk(8'd10, 8'h10, 8'd10, 8'd10, 1'b1));
        q_a.push_back(mk(8'd10, 8'h10, 8'd10, 8'd10, 1'b1));
        fps_ready = 1'b0;
        enable = 1'b1;
        tick(2);
        fork
            vs_run(31, 10);
            begin
                tick(150); chk("t2_valid_held", fps_valid, 1'b1);
                           chk("t2_ovf_before", overflow, 1'b0);
                tick(90);  chk("t2_valid_held2", fps_valid, 1'b1);
                           chk("t2_ovf_set", overflow, 1'b1);
                tick(10);  fps_ready = 1'b1;
                tick(2);   chk("t2_valid_drop", fps_valid, 1'b0);
                           chk("t2_ovf_sticky", overflow, 1'b1);
            end
        join
        tick(5);

        // 3: min/max tracking with clears between windows and on a load
        do_reset();
        q_a.push_back(mk(8'd10, 8'h10, 8'd10, 8'd10, 1'b0));
        q_a.push_back(mk(8'd5,  8'h05, 8'd5,  8'd5,  1'b0));
        q_a.push_back(mk(8'd10, 8'h10, 8'd5,  8'd10, 1'b0));
        q_a.push_back(mk(8'd10, 8'h10, 8'd10, 8'd10, 1'b0));
        enable = 1'b1;
        tick(2);
        fork
            begin
                vs_run(10, 10);
                vs_run(5, 20);
                vs_run(21, 10);
            end
            begin
                tick(150); clr_minmax = 1'b1;
                tick(1);   clr_minmax = 1'b0;
                tick(9);   chk("t3_clr_min", fps_min, 8'hFF);
                           chk("t3_clr_max", fps_max, 8'h00);
                tick(242); clr_minmax = 1'b1;
                tick(1);   clr_minmax = 1'b0;
            end
        join
        tick(5);

        // 4: stall inside RUN aborts the window, next edge re-arms
        do_reset();
        q_a.push_back(mk(8'd10, 8'h10, 8'd10, 8'd10, 1'b0));
        q_a.push_back(mk(8'd10, 8'h10, 8'd10, 8'd10, 1'b0));
        enable = 1'b1;
        tick(2);
        fork
            begin
                vs_run(11, 10);
                tick(60);
                vs_run(11, 10);
            end
            begin
                tick(142); chk("t4_not_stalled", stalled, 1'b0);
                tick(1);   chk("t4_stalled", stalled, 1'b1);
                tick(7);   chk("t4_no_valid", fps_valid, 1'b0);
                tick(22);  chk("t4_still_stalled", stalled, 1'b1);
                tick(2);   chk("t4_stall_clear", stalled, 1'b0);
            end
        join
        tick(5);

        // 5: period-3 vsync over 1000-cycle window saturates
        do_reset();
        q_b.push_back(mk(8'd255, 8'h99, 8'd255, 8'd255, 1'b0));
        enable5 = 1'b1;
        tick(2);
        for (int i = 0; i < 340; i++) begin
            vs5 = 1'b1;
            tick(1);
            vs5 = 1'b0;
            tick(2);
        end
        tick(5);

        // 6: enable dropped mid-window, re-enable re-arms
        do_reset();
        q_a.push_back(mk(8'd10, 8'h10, 8'd10, 8'd10, 1'b0));
        enable = 1'b1;
        tick(2);
        fork
            begin
                vs_run(6, 10);
                tick(40);
                vs_run(11, 10);
            end
            begin
                tick(53);  enable = 1'b0;
                tick(10);  chk("t6_valid_idle", fps_valid, 1'b0);
                           chk("t6_stalled_idle", stalled, 1'b0);
                           chk("t6_fps_held", fps, 8'h00);
                tick(17);  enable = 1'b1;
                tick(122); chk("t6_valid_pre", fps_valid, 1'b0);
                tick(1);   chk("t6_valid_load", fps_valid, 1'b1);
            end
        join
        tick(20);

        chk("pending_a", q_a.size(), 0);
        chk("pending_b", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
